pe_loop_ctl: RTL and testbench

Parametrised PE datapath controller. It sequences a 1-D row-stationary convolution loop nest over a configurable channel count, kernel width, filter count and output width. It loads the weight scratchpad and a per-channel ring-buffered input window through rdy/ack handshakes, then issues one MAC per cycle with input, weight and psum scratchpad addresses. It sits between the PE instruction/config front end and the PE pads/MAC datapath.

---
 rtl/pe_loop_ctl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_pe_loop_ctl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_loop_ctl.sv
// pe_loop_ctl: loop-nest sequencer for a 1-D row-stationary PE (weight load, windowed input load, MAC issue).
// Define PE_CFGCHK_EN to reject out-of-range configs at start with an o_err pulse.
module pe_loop_ctl #(
    parameter int unsigned CH_MAX = 16,
    parameter int unsigned KW_MAX = 8,
    parameter int unsigned NF_MAX = 16,
    parameter int unsigned OW_MAX = 64,
    localparam int unsigned CW  = $clog2(CH_MAX),
    localparam int unsigned KWW = $clog2(KW_MAX),
    localparam int unsigned FW  = $clog2(NF_MAX),
    localparam int unsigned OWW = $clog2(OW_MAX + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_stall,
    input  logic                  i_abort,
    input  logic [CW:0]           i_cfg_nch,
    input  logic [KWW:0]          i_cfg_kw,
    input  logic [FW:0]           i_cfg_nf,
    input  logic [OWW-1:0]        i_cfg_ow,
    input  logic                  i_in_rdy,
    output logic                  o_in_ack,
    output logic                  o_ip_we,
    output logic [CW+KWW-1:0]     o_ip_waddr,
    input  logic                  i_w_rdy,
    output logic                  o_w_ack,
    output logic                  o_wp_we,
    output logic [CW+KWW+FW-1:0]  o_wp_waddr,
    output logic                  o_mac_vld,
    output logic [CW+KWW-1:0]     o_ip_raddr,
    output logic [CW+KWW+FW-1:0]  o_wp_raddr,
    output logic [FW-1:0]         o_pp_addr,
    output logic                  o_pp_clr,
    output logic                  o_pp_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    typedef enum logic [2:0] {StIdle, StLdw, StLdi, StMac, StDone} state_e;

    state_e state_q, state_d;
    logic [CW:0]    nch_q, nch_d;
    logic [KWW:0]   kw_q, kw_d;
    logic [FW:0]    nf_q, nf_d;
    logic [OWW-1:0] ow_q, ow_d, o_q, o_d;
    logic [CW-1:0]  c_q, c_d, c_step;
    logic [KWW-1:0] k_q, k_d, k_step, head_q, head_d, head_inc, rd_slot, wr_slot;
    logic [FW-1:0]  f_q, f_d, f_step;

    logic in_ack_q, in_ack_d, ip_we_q, ip_we_d, w_ack_q, w_ack_d, wp_we_q, wp_we_d;
    logic mac_vld_q, mac_vld_d, pp_clr_q, pp_clr_d, pp_last_q, pp_last_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CW+KWW-1:0]    ip_waddr_q, ip_waddr_d, ip_raddr_q, ip_raddr_d;
    logic [CW+KWW+FW-1:0] wp_waddr_q, wp_waddr_d, wp_raddr_q, wp_raddr_d;
    logic [FW-1:0]        pp_addr_q, pp_addr_d;

    logic f_last, k_last, c_last, o_last, all_last, first_pos;
    logic [KWW:0] slot_sum;

    assign f_last    = ((FW+1)'(f_q) + (FW+1)'(1)) == nf_q;
    assign k_last    = ((KWW+1)'(k_q) + (KWW+1)'(1)) == kw_q;
    assign c_last    = ((CW+1)'(c_q) + (CW+1)'(1)) == nch_q;
    assign o_last    = (o_q + OWW'(1)) == ow_q;
    assign all_last  = f_last && k_last && c_last;
    assign first_pos = (o_q == '0);

    // Ring-buffer arithmetic: both operands are below kw, so one conditional subtract suffices.
    assign slot_sum = (KWW+1)'(head_q) + (KWW+1)'(k_q);
    assign rd_slot  = (slot_sum >= kw_q) ? KWW'(slot_sum - kw_q) : KWW'(slot_sum);
    assign head_inc = (((KWW+1)'(head_q) + (KWW+1)'(1)) == kw_q) ? '0 : head_q + KWW'(1);
    assign wr_slot  = first_pos ? k_q : head_q;

`ifdef PE_CFGCHK_EN
    logic cfg_bad;
    assign cfg_bad = (i_cfg_nch == '0) || (i_cfg_nch > (CW+1)'(CH_MAX)) ||
                     (i_cfg_kw == '0)  || (i_cfg_kw > (KWW+1)'(KW_MAX)) ||
                     (i_cfg_nf == '0)  || (i_cfg_nf > (FW+1)'(NF_MAX)) ||
                     (i_cfg_ow == '0)  || (i_cfg_ow > OWW'(OW_MAX));
`endif

    // Shared {c,k,f} stepper, f innermost; wraps to all-zero after the last index.
    always_comb begin
        f_step = f_q;
        k_step = k_q;
        c_step = c_q;
        if (!f_last) begin
            f_step = f_q + FW'(1);
        end else begin
            f_step = '0;
            if (!k_last) begin
                k_step = k_q + KWW'(1);
            end else begin
                k_step = '0;
                c_step = c_last ? '0 : c_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        nch_d      = nch_q;
        kw_d       = kw_q;
        nf_d       = nf_q;
        ow_d       = ow_q;
        o_d        = o_q;
        c_d        = c_q;
        k_d        = k_q;
        f_d        = f_q;
        head_d     = head_q;
        ip_we_d    = 1'b0;
        ip_waddr_d = '0;
        wp_we_d    = 1'b0;
        wp_waddr_d = '0;
        mac_vld_d  = 1'b0;
        ip_raddr_d = '0;
        wp_raddr_d = '0;
        pp_addr_d  = '0;
        pp_clr_d   = 1'b0;
        pp_last_d  = 1'b0;
        err_d      = 1'b0;
        if (i_abort) begin
            state_d = StIdle;
            o_d     = '0;
            c_d     = '0;
            k_d     = '0;
            f_d     = '0;
            head_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
`ifdef PE_CFGCHK_EN
                        if (cfg_bad) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = StLdw;
                            nch_d   = i_cfg_nch;
                            kw_d    = i_cfg_kw;
                            nf_d    = i_cfg_nf;
                            ow_d    = i_cfg_ow;
                        end
`else
                        state_d = StLdw;
                        nch_d   = i_cfg_nch;
                        kw_d    = i_cfg_kw;
                        nf_d    = i_cfg_nf;
                        ow_d    = i_cfg_ow;
`endif
                    end
                end
                StLdw: begin
                    if (i_w_rdy && w_ack_q) begin
                        wp_we_d    = 1'b1;
                        wp_waddr_d = {c_q, k_q, f_q};
                        c_d        = c_step;
                        k_d        = k_step;
                        f_d        = f_step;
                        if (all_last) state_d = StLdi;
                    end
                end
                StLdi: begin
                    if (i_in_rdy && in_ack_q) begin
                        ip_we_d    = 1'b1;
                        ip_waddr_d = {c_q, wr_slot};
                        if (!c_last) begin
                            c_d = c_q + CW'(1);
                        end else begin
                            c_d = '0;
                            if (!first_pos) begin
                                head_d  = head_inc;
                                state_d = StMac;
                            end else if (k_last) begin
                                k_d     = '0;
                                state_d = StMac;
                            end else begin
                                k_d = k_q + KWW'(1);
                            end
                        end
                    end
                end
                StMac: begin
                    if (!i_stall) begin
                        mac_vld_d  = 1'b1;
                        ip_raddr_d = {c_q, rd_slot};
                        wp_raddr_d = {c_q, k_q, f_q};
                        pp_addr_d  = f_q;
                        pp_clr_d   = (c_q == '0) && (k_q == '0);
                        pp_last_d  = c_last && k_last;
                        c_d        = c_step;
                        k_d        = k_step;
                        f_d        = f_step;
                        if (all_last) begin
                            if (o_last) begin
                                state_d = StDone;
                            end else begin
                                o_d     = o_q + OWW'(1);
                                state_d = StLdi;
                            end
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    o_d     = '0;
                    head_d  = '0;
                end
                default: state_d = StIdle;
            endcase
        end
        w_ack_d  = (state_d == StLdw);
        in_ack_d = (state_d == StLdi);
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            nch_q      <= '0;
            kw_q       <= '0;
            nf_q       <= '0;
            ow_q       <= '0;
            o_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            f_q        <= '0;
            head_q     <= '0;
            in_ack_q   <= 1'b0;
            ip_we_q    <= 1'b0;
            ip_waddr_q <= '0;
            w_ack_q    <= 1'b0;
            wp_we_q    <= 1'b0;
            wp_waddr_q <= '0;
            mac_vld_q  <= 1'b0;
            ip_raddr_q <= '0;
            wp_raddr_q <= '0;
            pp_addr_q  <= '0;
            pp_clr_q   <= 1'b0;
            pp_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nch_q      <= nch_d;
            kw_q       <= kw_d;
            nf_q       <= nf_d;
            ow_q       <= ow_d;
            o_q        <= o_d;
            c_q        <= c_d;
            k_q        <= k_d;
            f_q        <= f_d;
            head_q     <= head_d;
            in_ack_q   <= in_ack_d;
            ip_we_q    <= ip_we_d;
            ip_waddr_q <= ip_waddr_d;
            w_ack_q    <= w_ack_d;
            wp_we_q    <= wp_we_d;
            wp_waddr_q <= wp_waddr_d;
            mac_vld_q  <= mac_vld_d;
            ip_raddr_q <= ip_raddr_d;
            wp_raddr_q <= wp_raddr_d;
            pp_addr_q  <= pp_addr_d;
            pp_clr_q   <= pp_clr_d;
            pp_last_q  <= pp_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_in_ack   = in_ack_q;
    assign o_ip_we    = ip_we_q;
    assign o_ip_waddr = ip_waddr_q;
    assign o_w_ack    = w_ack_q;
    assign o_wp_we    = wp_we_q;
    assign o_wp_waddr = wp_waddr_q;
    assign o_mac_vld  = mac_vld_q;
    assign o_ip_raddr = ip_raddr_q;
    assign o_wp_raddr = wp_raddr_q;
    assign o_pp_addr  = pp_addr_q;
    assign o_pp_clr   = pp_clr_q;
    assign o_pp_last  = pp_last_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
`ifdef PE_CFGCHK_EN
    assign o_err      = err_q;
`else
    assign o_err      = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_pe_loop_ctl.sv
// tb_pe_loop_ctl: checks pe_loop_ctl against an event-list model of the loop nest
// (weight writes, input writes, MAC issues) under random handshake gaps and stalls.
module tb_pe_loop_ctl;
    localparam int CH_MAX = 16, KW_MAX = 8, NF_MAX = 16, OW_MAX = 64;
    localparam int CW = 4, KWW = 3, FW = 4, OWW = 7;
    localparam int IPW = CW + KWW, WPW = CW + KWW + FW;

    logic i_clk = 1'b0, i_rst = 1'b0, i_start = 1'b0, i_stall = 1'b0, i_abort = 1'b0;
    logic [CW:0] i_cfg_nch = '0;
    logic [KWW:0] i_cfg_kw = '0;
    logic [FW:0] i_cfg_nf = '0;
    logic [OWW-1:0] i_cfg_ow = '0;
    logic i_in_rdy = 1'b0, i_w_rdy = 1'b0;
    logic o_in_ack, o_ip_we, o_w_ack, o_wp_we, o_mac_vld, o_pp_clr, o_pp_last;
    logic o_busy, o_done, o_err;
    logic [IPW-1:0] o_ip_waddr, o_ip_raddr;
    logic [WPW-1:0] o_wp_waddr, o_wp_raddr;
    logic [FW-1:0] o_pp_addr;

    pe_loop_ctl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stall(i_stall), .i_abort(i_abort),
        .i_cfg_nch(i_cfg_nch), .i_cfg_kw(i_cfg_kw), .i_cfg_nf(i_cfg_nf), .i_cfg_ow(i_cfg_ow),
        .i_in_rdy(i_in_rdy), .o_in_ack(o_in_ack), .o_ip_we(o_ip_we), .o_ip_waddr(o_ip_waddr),
        .i_w_rdy(i_w_rdy), .o_w_ack(o_w_ack), .o_wp_we(o_wp_we), .o_wp_waddr(o_wp_waddr),
        .o_mac_vld(o_mac_vld), .o_ip_raddr(o_ip_raddr), .o_wp_raddr(o_wp_raddr),
        .o_pp_addr(o_pp_addr), .o_pp_clr(o_pp_clr), .o_pp_last(o_pp_last),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0, n_fail = 0;
    int mac_seen = 0, done_cnt = 0, per_pos = 1, cyc = 0, first_cyc = 0, last_cyc = 0;
    int rdy_mode = 0;
    bit stall_mode = 1'b0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({o_in_ack, o_ip_we, o_ip_waddr, o_w_ack, o_wp_we, o_wp_waddr, o_mac_vld,
                    o_ip_raddr, o_wp_raddr, o_pp_addr, o_pp_clr, o_pp_last, o_busy, o_done,
                    o_err});
    endfunction

    function automatic logic [63:0] ev_w(input int c, input int k, input int f);
        return {2'd0, 62'(c * KW_MAX * NF_MAX + k * NF_MAX + f)};
    endfunction

    function automatic logic [63:0] ev_i(input int c, input int s);
        return {2'd1, 62'(c * KW_MAX + s)};
    endfunction

    function automatic logic [63:0] ev_m(input int ip, input int wp, input int pp,
                                         input int clr, input int last);
        longint v;
        v = (((longint'(ip) * (2 ** WPW) + wp) * (2 ** FW) + pp) * 2 + clr) * 2 + last;
        return {2'd2, 62'(v)};
    endfunction

    // Expected event list for one job, straight from the loop-nest description.
    task automatic build(input int nch, input int kw, input int nf, input int ow);
        int head;
        head = 0;
        for (int c = 0; c < nch; c++)
            for (int k = 0; k < kw; k++)
                for (int f = 0; f < nf; f++) exp_q.push_back(ev_w(c, k, f));
        for (int o = 0; o < ow; o++) begin
            if (o == 0) begin
                for (int s = 0; s < kw; s++)
                    for (int c = 0; c < nch; c++) exp_q.push_back(ev_i(c, s));
            end else begin
                for (int c = 0; c < nch; c++) exp_q.push_back(ev_i(c, head));
                head = (head + 1) % kw;
            end
            for (int c = 0; c < nch; c++)
                for (int k = 0; k < kw; k++)
                    for (int f = 0; f < nf; f++)
                        exp_q.push_back(ev_m(c * KW_MAX + (head + k) % kw,
                                             c * KW_MAX * NF_MAX + k * NF_MAX + f, f,
                                             int'(c == 0 && k == 0),
                                             int'(c == nch - 1 && k == kw - 1)));
        end
    endtask

    // Compare process: every write/issue cycle is matched against the head of the model list.
    initial begin
        int n;
        logic [63:0] act;
        forever begin
            @(negedge i_clk);
            cyc++;
            n = int'(o_wp_we) + int'(o_ip_we) + int'(o_mac_vld);
            if (o_done) done_cnt++;
            if (o_mac_vld) begin
                mac_seen++;
                if (mac_seen == 1) first_cyc = cyc;
                if (mac_seen == per_pos) last_cyc = cyc;
            end
            if (n > 1) check("event_overlap", 64'(n), 64'd1);
            if (n != 0) begin
                if (o_wp_we) act = {2'd0, 62'(o_wp_waddr)};
                else if (o_ip_we) act = {2'd1, 62'(o_ip_waddr)};
                else act = {2'd2, 62'({o_ip_raddr, o_wp_raddr, o_pp_addr, o_pp_clr, o_pp_last})};
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL event_unexpected: got %0h, required none", act);
                end else begin
                    check("event", act, exp_q.pop_front());
                end
            end
        end
    end

    // Handshake/stall driver: 0 = always ready, 1 = random gaps, 2 = every other cycle.
    initial begin
        bit tog;
        tog = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            tog = ~tog;
            case (rdy_mode)
                1: begin
                    i_w_rdy  = ($urandom_range(0, 3) != 0);
                    i_in_rdy = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    i_w_rdy  = tog;
                    i_in_rdy = tog;
                end
                default: begin
                    i_w_rdy  = 1'b1;
                    i_in_rdy = 1'b1;
                end
            endcase
            if (stall_mode) i_stall = ($urandom_range(0, 4) == 0);
        end
    end

    // mode 0: plain run, 1: 3-cycle stall after first MAC, 2: abort in the second LDI.
    task automatic run_job(input int nch, input int kw, input int nf, input int ow, input int mode);
        int cnt;
        exp_q.delete();
        build(nch, kw, nf, ow);
        per_pos  = nch * kw * nf;
        mac_seen = 0;
        done_cnt = 0;
        @(posedge i_clk);
        #1;
        i_cfg_nch = 5'(nch);
        i_cfg_kw  = 4'(kw);
        i_cfg_nf  = 5'(nf);
        i_cfg_ow  = 7'(ow);
        i_start   = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        check("w_ack_after_start", 64'(o_w_ack), 64'd1);
        check("busy_after_start", 64'(o_busy), 64'd1);
        if (mode == 2) begin
            cnt = 0;
            do begin
                @(posedge i_clk);
                #1;
                cnt++;
            end while (!(o_in_ack && o_mac_vld) && cnt < 20000);
            check("second_ldi_reached", 64'(o_in_ack && o_mac_vld), 64'd1);
            i_abort = 1'b1;
            @(posedge i_clk);
            #1;
            i_abort = 1'b0;
            check("abort_outputs_zero", outs(), 64'd0);
            repeat (6) @(posedge i_clk);
            #1;
            check("abort_no_done", 64'(done_cnt), 64'd0);
            check("abort_stays_idle", 64'(o_busy), 64'd0);
            exp_q.delete();
            return;
        end
        if (mode == 1) begin
            cnt = 0;
            while (o_mac_vld !== 1'b1 && cnt < 20000) begin
                @(negedge i_clk);
                cnt++;
            end
            @(posedge i_clk);
            #1;
            i_stall = 1'b1;
            repeat (3) @(posedge i_clk);
            #1;
            i_stall = 1'b0;
        end
        cnt = 0;
        while (o_done !== 1'b1 && cnt < 20000) begin
            @(negedge i_clk);
            cnt++;
        end
        check("done_seen", 64'(o_done), 64'd1);
        @(posedge i_clk);
        #1;
        check("done_one_cycle", 64'(o_done), 64'd0);
        check("idle_after_done", 64'(o_busy), 64'd0);
        check("done_count", 64'(done_cnt), 64'd1);
        check("events_left", 64'(exp_q.size()), 64'd0);
        check("mac_total", 64'(mac_seen), 64'(per_pos * ow));
        if (mode == 1) check("stall_gap_cycles", 64'(last_cyc - first_cyc + 1 - per_pos), 64'd3);
    endtask

    initial begin
        #12;
        check("reset_outputs", outs(), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;

        // Pin the model against hand-derived values before trusting it.
        exp_q.delete();
        build(1, 1, 1, 1);
        check("model_1111_len", 64'(exp_q.size()), 64'd3);
        check("model_1111_w", exp_q[0], 64'h0);
        check("model_1111_i", exp_q[1], 64'h4000_0000_0000_0000);
        check("model_1111_m", exp_q[2], 64'h8000_0000_0000_0003);
        exp_q.delete();
        build(2, 3, 2, 2);
        check("model_2322_len", 64'(exp_q.size()), 64'd44);
        check("model_2322_w2", exp_q[2], 64'h10);
        check("model_2322_mlast0", exp_q[29], 64'h8000_0000_0014_2845);
        check("model_2322_i31", exp_q[31], 64'h4000_0000_0000_0008);
        check("model_2322_m32", exp_q[32], 64'h8000_0000_0002_0002);
        exp_q.delete();

        run_job(1, 1, 1, 1, 0);
        run_job(2, 3, 2, 2, 0);
        rdy_mode = 2;
        run_job(2, 3, 2, 2, 0);
        rdy_mode = 0;
        run_job(2, 3, 4, 2, 1);
        run_job(2, 3, 2, 3, 2);
        run_job(2, 3, 2, 3, 0);
        run_job(CH_MAX, KW_MAX, NF_MAX, 2, 0);
        run_job(1, 2, 1, OW_MAX, 0);

        rdy_mode   = 1;
        stall_mode = 1'b1;
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 4), $urandom_range(1, KW_MAX), $urandom_range(1, 4),
                    $urandom_range(1, 6), 0);
        stall_mode = 1'b0;
        i_stall    = 1'b0;
        rdy_mode   = 0;

`ifdef PE_CFGCHK_EN
        for (int j = 0; j < 2; j++) begin
            @(posedge i_clk);
            #1;
            i_cfg_nch = 5'd2;
            i_cfg_kw  = (j == 0) ? 4'd0 : 4'd3;
            i_cfg_nf  = (j == 0) ? 5'd2 : 5'(NF_MAX + 1);
            i_cfg_ow  = 7'd2;
            i_start   = 1'b1;
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            check("cfg_err_pulse", 64'(o_err), 64'd1);
            check("cfg_err_not_busy", 64'(o_busy), 64'd0);
            check("cfg_err_no_ack", 64'(o_w_ack), 64'd0);
            @(posedge i_clk);
            #1;
            check("cfg_err_one_cycle", 64'(o_err), 64'd0);
            check("cfg_err_still_idle", 64'(o_busy), 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
